// File: rtl/alu_multicycle_unit.sv
// Execute-stage ALU: decodes {funct7, ALU_Op, funct3} into a 4-bit op code and runs it.
// Logic/arithmetic ops finish in one cycle; shifts iterate SHIFT_STEP bits per cycle.
module alu_multicycle_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  funct7_i,
  input  logic [2:0]            ALU_Op_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  illegal_o,
  output logic [3:0]            ALU_Operation_o
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [SHW-1:0] STEP_C = SHW'(SHIFT_STEP);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_ILL = 4'b1111;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  // funct7 only matters for R-type ADD/SUB and for the right shifts
  function automatic logic [3:0] decode_op(input logic f7, input logic [2:0] alu_op,
                                           input logic [2:0] f3);
    logic [3:0] op;
    op = OP_ILL;
    case (alu_op)
      3'b000, 3'b001: begin
        case (f3)
          3'b000:  op = (f7 && (alu_op == 3'b000)) ? OP_SUB : OP_ADD;
          3'b001:  op = OP_SLL;
          3'b100:  op = OP_XOR;
          3'b101:  op = f7 ? OP_SRA : OP_SRL;
          3'b110:  op = OP_OR;
          3'b111:  op = OP_AND;
          default: op = OP_ILL;
        endcase
      end
      3'b010:  op = OP_LUI;
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

  state_t                state_r, state_nxt_s;
  logic [3:0]            op_s, op_r;
  logic [SHW-1:0]        shamt_s, rem_r, step_amt_s;
  logic [DATA_WIDTH-1:0] wrk_r, single_res_s, shifted_s;
  logic                  accept_s, is_shift_s, shift_start_s, shift_last_s;
  logic                  done_r, zero_r, illegal_r;
  logic [DATA_WIDTH-1:0] result_r;

  assign op_s          = decode_op(funct7_i, ALU_Op_i, funct3_i);
  assign shamt_s       = b_i[SHW-1:0];
  assign is_shift_s    = (op_s == OP_SLL) || (op_s == OP_SRL) || (op_s == OP_SRA);
  assign ready_o       = (state_r == ST_IDLE) && !reset;
  assign accept_s      = start_i && ready_o;
  assign shift_start_s = accept_s && is_shift_s && (shamt_s != {SHW{1'b0}});
  assign shift_last_s  = (rem_r == step_amt_s);

  // Single-cycle result; a shift reaching here has amount 0 and returns a_i
  always_comb begin
    single_res_s = {DATA_WIDTH{1'b0}};
    case (op_s)
      OP_ADD:                 single_res_s = a_i + b_i;
      OP_SUB:                 single_res_s = a_i - b_i;
      OP_AND:                 single_res_s = a_i & b_i;
      OP_OR:                  single_res_s = a_i | b_i;
      OP_XOR:                 single_res_s = a_i ^ b_i;
      OP_LUI:                 single_res_s = b_i;
      OP_SLL, OP_SRL, OP_SRA: single_res_s = a_i;
      default:                single_res_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // One iteration of the shifter, never past the remaining count
  always_comb begin
    step_amt_s = STEP_C;
    if (rem_r < STEP_C) begin
      step_amt_s = rem_r;
    end else begin
      step_amt_s = STEP_C;
    end
    shifted_s = wrk_r;
    case (op_r)
      OP_SLL:  shifted_s = wrk_r << step_amt_s;
      OP_SRL:  shifted_s = wrk_r >> step_amt_s;
      OP_SRA:  shifted_s = $unsigned($signed(wrk_r) >>> step_amt_s);
      default: shifted_s = wrk_r;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (shift_start_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (shift_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, shifter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_ADD;
      rem_r     <= {SHW{1'b0}};
      wrk_r     <= {DATA_WIDTH{1'b0}};
      result_r  <= {DATA_WIDTH{1'b0}};
      zero_r    <= 1'b0;
      illegal_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r <= op_s;
            if (shift_start_s) begin
              wrk_r <= a_i;
              rem_r <= shamt_s;
            end else begin
              result_r  <= single_res_s;
              zero_r    <= (single_res_s == {DATA_WIDTH{1'b0}});
              illegal_r <= (op_s == OP_ILL);
              done_r    <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          wrk_r <= shifted_s;
          rem_r <= rem_r - step_amt_s;
          if (shift_last_s) begin
            result_r  <= shifted_s;
            zero_r    <= (shifted_s == {DATA_WIDTH{1'b0}});
            illegal_r <= 1'b0;
            done_r    <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign done_o          = done_r;
  assign result_o        = result_r;
  assign zero_o          = zero_r;
  assign illegal_o       = illegal_r;
  assign ALU_Operation_o = op_r;

endmodule

// File: tb/tb_alu_multicycle_unit.sv
// Directed bench for alu_multicycle_unit: a vector table run on a SHIFT_STEP=1 and a
// SHIFT_STEP=4 instance, plus hand sequences for back-to-back, busy and reset abort.
module tb_alu_multicycle_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        funct7_i;
  logic [2:0]  ALU_Op_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i;
  logic [31:0] b_i;

  logic        ready1, done1, zero1, ill1;
  logic [31:0] result1;
  logic [3:0]  code1;
  logic        ready4, done4, zero4, ill4;
  logic [31:0] result4;
  logic [3:0]  code4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_multicycle_unit #(.DATA_WIDTH(32), .SHIFT_STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start_i(start_i), .funct7_i(funct7_i), .ALU_Op_i(ALU_Op_i),
    .funct3_i(funct3_i), .a_i(a_i), .b_i(b_i), .ready_o(ready1), .done_o(done1),
    .result_o(result1), .zero_o(zero1), .illegal_o(ill1), .ALU_Operation_o(code1));

  alu_multicycle_unit #(.DATA_WIDTH(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start_i(start_i), .funct7_i(funct7_i), .ALU_Op_i(ALU_Op_i),
    .funct3_i(funct3_i), .a_i(a_i), .b_i(b_i), .ready_o(ready4), .done_o(done4),
    .result_o(result4), .zero_o(zero4), .illegal_o(ill4), .ALU_Operation_o(code4));

  typedef struct {
    logic        f7;
    logic [2:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    logic [3:0]  code;
    int          lat1;
    int          lat4;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic f7, input logic [2:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    funct7_i = f7;
    ALU_Op_i = op;
    funct3_i = f3;
    a_i      = a;
    b_i      = b;
    start_i  = 1'b1;
  endtask

  initial begin
    int          got1, got4, n1, n4;
    logic [31:0] r1, r4;
    logic        z1, z4, il1, il4;
    logic [3:0]  cd1, cd4;

    vecs[0]  = '{1'b0, 3'b000, 3'b000, 32'h5,        32'h7,        32'hC,        1'b0, 4'h0, 1, 1};
    vecs[1]  = '{1'b1, 3'b000, 3'b000, 32'h9,        32'h9,        32'h0,        1'b0, 4'h1, 1, 1};
    vecs[2]  = '{1'b0, 3'b000, 3'b000, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 4'h0, 1, 1};
    vecs[3]  = '{1'b0, 3'b001, 3'b001, 32'h1,        32'h5,        32'h20,       1'b0, 4'h8, 6, 3};
    vecs[4]  = '{1'b1, 3'b000, 3'b101, 32'h80000000, 32'h4,        32'hF8000000, 1'b0, 4'hB, 5, 2};
    vecs[5]  = '{1'b0, 3'b000, 3'b101, 32'h80000000, 32'h4,        32'h08000000, 1'b0, 4'hA, 5, 2};
    vecs[6]  = '{1'b0, 3'b000, 3'b101, 32'h80000000, 32'h0,        32'h80000000, 1'b0, 4'hA, 1, 1};
    vecs[7]  = '{1'b0, 3'b011, 3'b000, 32'h1234,     32'h5678,     32'h0,        1'b1, 4'hF, 1, 1};
    vecs[8]  = '{1'b0, 3'b010, 3'b011, 32'hDEAD,     32'h12345000, 32'h12345000, 1'b0, 4'h7, 1, 1};
    vecs[9]  = '{1'b0, 3'b000, 3'b111, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 4'h4, 1, 1};
    vecs[10] = '{1'b0, 3'b001, 3'b110, 32'hF0,       32'h0F,       32'hFF,       1'b0, 4'h5, 1, 1};
    vecs[11] = '{1'b0, 3'b000, 3'b100, 32'hFF,       32'h0F,       32'hF0,       1'b0, 4'h6, 1, 1};
    vecs[12] = '{1'b1, 3'b001, 3'b101, 32'hF0000000, 32'h23,       32'hFE000000, 1'b0, 4'hB, 4, 2};
    vecs[13] = '{1'b0, 3'b000, 3'b001, 32'h1,        32'h1F,       32'h80000000, 1'b0, 4'h8, 32, 9};
    vecs[14] = '{1'b1, 3'b001, 3'b000, 32'hA,        32'hFFFFFFFF, 32'h9,        1'b0, 4'h0, 1, 1};
    vecs[15] = '{1'b0, 3'b000, 3'b010, 32'h3,        32'h4,        32'h0,        1'b1, 4'hF, 1, 1};

    reset = 1'b1;
    start_i = 1'b0;
    funct7_i = 1'b0;
    ALU_Op_i = 3'b000;
    funct3_i = 3'b000;
    a_i = 32'h0;
    b_i = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", ready1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_result", result1, 32'h0);
    chk("rst_zero", zero1, 1'b0);
    chk("rst_illegal", ill1, 1'b0);
    chk("rst_code", code1, 4'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready1, 1'b1);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].f7, vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b);
      got1 = 0; got4 = 0; n1 = 0; n4 = 0;
      r1 = 32'h0; r4 = 32'h0; z1 = 1'b0; z4 = 1'b0; il1 = 1'b0; il4 = 1'b0;
      cd1 = 4'h0; cd4 = 4'h0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (c == 1) start_i = 1'b0;
        if (done1) begin
          n1++;
          if (got1 == 0) begin got1 = c; r1 = result1; z1 = zero1; il1 = ill1; cd1 = code1; end
        end
        if (done4) begin
          n4++;
          if (got4 == 0) begin got4 = c; r4 = result4; z4 = zero4; il4 = ill4; cd4 = code4; end
        end
      end
      chk($sformatf("v%0d_lat1", i), got1, vecs[i].lat1);
      chk($sformatf("v%0d_lat4", i), got4, vecs[i].lat4);
      chk($sformatf("v%0d_pulses1", i), n1, 1);
      chk($sformatf("v%0d_pulses4", i), n4, 1);
      chk($sformatf("v%0d_result1", i), r1, vecs[i].res);
      chk($sformatf("v%0d_result4", i), r4, vecs[i].res);
      chk($sformatf("v%0d_zero1", i), z1, vecs[i].res == 32'h0);
      chk($sformatf("v%0d_zero4", i), z4, vecs[i].res == 32'h0);
      chk($sformatf("v%0d_illegal1", i), il1, vecs[i].ill);
      chk($sformatf("v%0d_illegal4", i), il4, vecs[i].ill);
      chk($sformatf("v%0d_code1", i), cd1, vecs[i].code);
      chk($sformatf("v%0d_code4", i), cd4, vecs[i].code);
    end

    // Back-to-back single-cycle ops: SUB to zero then wrapping ADD
    drive(1'b1, 3'b000, 3'b000, 32'h9, 32'h9);
    @(negedge clk);
    chk("b2b_done_a", done1, 1'b1);
    chk("b2b_result_a", result1, 32'h0);
    chk("b2b_zero_a", zero1, 1'b1);
    chk("b2b_code_a", code1, 4'h1);
    drive(1'b0, 3'b000, 3'b000, 32'hFFFFFFFF, 32'h1);
    @(negedge clk);
    start_i = 1'b0;
    chk("b2b_done_b", done1, 1'b1);
    chk("b2b_result_b", result1, 32'h0);
    chk("b2b_zero_b", zero1, 1'b1);
    chk("b2b_code_b", code1, 4'h0);
    chk("b2b_ready_b", ready1, 1'b1);
    @(negedge clk);
    chk("b2b_done_clear", done1, 1'b0);

    // Start while busy is ignored (SHIFT_STEP=1 instance)
    drive(1'b0, 3'b001, 3'b001, 32'h1, 32'h5);
    got1 = 0; n1 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("busy_ready_low", ready1, 1'b0);
        drive(1'b0, 3'b000, 3'b000, 32'h3, 32'h4);
      end
      if (c == 3) start_i = 1'b0;
      if (done1) begin
        n1++;
        if (got1 == 0) got1 = c;
      end
    end
    chk("busy_lat", got1, 6);
    chk("busy_pulses", n1, 1);
    chk("busy_result", result1, 32'h20);
    chk("busy_code", code1, 4'h8);

    // Reset on the 2nd shift cycle aborts; reset beats a simultaneous start
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(1'b0, 3'b001, 3'b001, 32'h1, 32'h5);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("abort_shifting", ready1, 1'b0);
    reset = 1'b1;
    drive(1'b0, 3'b000, 3'b000, 32'h5, 32'h7);
    n1 = 0;
    @(negedge clk);
    start_i = 1'b0;
    chk("abort_ready_in_reset", ready1, 1'b0);
    chk("abort_result", result1, 32'h0);
    chk("abort_code", code1, 4'h0);
    if (done1) n1++;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", ready1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      if (done1) n1++;
      @(negedge clk);
    end
    chk("abort_no_done", n1, 0);
    chk("abort_result_held", result1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_multicycle_unit.md
# alu_multicycle_unit

Parametrised execute-stage block that merges ALU operation decode and datapath: decodes {funct7, ALU_Op, funct3} into a 4-bit operation code, then executes it on DATA_WIDTH-bit operands. Logic and arithmetic ops complete in one cycle. Shifts run iteratively, SHIFT_STEP bits per cycle, behind a start/ready/done handshake. It sits between the main control unit / register file and the writeback mux. It is the multicycle successor of the purely combinational ALU control decode.

## Interface
- DATA_WIDTH, 32, operand/result width; power of two, 8..64
- SHIFT_STEP, 1, max bit positions shifted per cycle; 1..DATA_WIDTH/2
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start_i  in  1  request; accepted when start_i && ready_o at a rising edge
- funct7_i  in  1  instruction bit 30
- ALU_Op_i  in  3  000 R-type, 001 I-type ALU, 010 LUI; others illegal
- funct3_i  in  3  instruction funct3
- a_i  in  DATA_WIDTH  operand A (rs1)
- b_i  in  DATA_WIDTH  operand B (rs2 / immediate); shift amount = b_i[$clog2(DATA_WIDTH)-1:0]
- ready_o  out  1  high when idle and not in reset
- done_o  out  1  one-cycle pulse, result_o valid
- result_o  out  DATA_WIDTH  registered result, held until next completion
- zero_o  out  1  registered (result_o == 0)
- illegal_o  out  1  registered, valid with done_o
- ALU_Operation_o  out  4  registered decoded code of last accepted op

## Operation
- Decode (funct7 ignored unless stated):
  - R-type: 000 ADD (f7=0) / SUB (f7=1), 001 SLL, 100 XOR, 101 SRL (f7=0) / SRA (f7=1), 110 OR, 111 AND.
  - I-type: 000 ADDI, 001 SLLI, 100 XORI, 101 SRLI/SRAI by f7, 110 ORI, 111 ANDI.
  - LUI: any funct3, result = b_i.
  - Any other combination is illegal.
- Operation codes: ADD 0000, SUB 0001, AND 0100, OR 0101, XOR 0110, LUI 0111, SLL 1000, SRL 1010, SRA 1011, illegal 1111.
- Arithmetic: ADD/SUB modulo 2^DATA_WIDTH; no carry/overflow output. SRA fills with a_i MSB captured at accept.
- FSM has two states:
  - IDLE: ready_o=1. On accept of a non-shift op, an illegal op, or a shift with amount 0:
    - Compute the result (shift by 0 gives a_i; illegal gives 0, illegal_o=1).
    - Load result_o, zero_o, illegal_o and ALU_Operation_o at that edge, pulse done_o next cycle, stay in IDLE.
  - On accept of a shift with amount n>0:
    - Load the working register with a_i and the remaining count with n, latch the code, go to SHIFT.
  - SHIFT: ready_o=0. Each edge shifts the working register by min(SHIFT_STEP, remaining) and decrements remaining by the same amount.
    - At the edge where remaining reaches 0: load result_o and zero_o, set illegal_o=0, pulse done_o, return to IDLE.
- start_i while ready_o=0 is ignored; no queueing. Operands are only sampled at accept and may change afterwards.
- Reset values: state IDLE, result_o=0, zero_o=0, done_o=0, illegal_o=0, ALU_Operation_o=0000, ready_o=0 while reset is high.

## Timing
- Single-cycle ops: accept at edge E0 → done_o and result_o valid in the cycle after E0 (latency 1). Back-to-back accepts on every edge are allowed; done_o stays high on consecutive cycles.
- Shift, n>0: k = ceil(n/SHIFT_STEP) shift edges.
  - done_o is high in the cycle after edge E0+k (latency k+1).
  - ready_o is low for cycles E0+1..E0+k and high again in the done cycle, so a new accept is possible at the edge ending the done cycle.
- done_o is high for exactly one cycle per accepted op.
- Reset asserted mid-shift: the op is aborted, no done_o pulse, all outputs return to reset values at that edge.
- reset and start_i in the same cycle: reset wins, nothing is accepted.

## Test plan
- Reset then ADD: reset 2 cycles, then start with R-type f3=000 f7=0, a=5, b=7 → next cycle done_o=1, result_o=12, zero_o=0, ALU_Operation_o=0000, ready_o stays 1.
- SUB to zero plus wrap: SUB a=9, b=9 → result 0, zero_o=1. Then ADD a=FFFFFFFF, b=1 → result 0, zero_o=1. Both accepted on consecutive edges with two consecutive done_o cycles.
- Iterative shift: SHIFT_STEP=1, SLLI a=1, b=5 → ready_o low for 5 cycles, done_o in 6th cycle after accept, result 0x20. Repeat with SHIFT_STEP=4 → done in 3rd cycle, same result.
- SRA vs SRL: a=0x80000000, b=4 → SRA gives 0xF8000000, SRL gives 0x08000000. Shift amount 0 → result a, single-cycle.
- Illegal and LUI: ALU_Op=011 → done_o=1, illegal_o=1, result 0, ALU_Operation_o=1111. LUI b=0x12345000 → result 0x12345000, illegal_o=0.
- Busy and reset abort: start during SHIFT is ignored and the result is unchanged. Assert reset on the 2nd shift cycle → no done_o, ready_o high in the cycle after reset deasserts, result_o=0.
